// File: rtl/nzet_scatter_if.sv
// Stream bundle for nzet_scatter: compressed input beat and dense output beat.
interface nzet_scatter_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] val_0;
    logic [DW-1:0] val_1;
    logic [3:0]    mask_in;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] aout0;
    logic [DW-1:0] aout1;
    logic [DW-1:0] aout2;
    logic [DW-1:0] aout3;
    logic [3:0]    mask_out;

    modport master (
        output in_valid, val_0, val_1, mask_in, out_ready,
        input  in_ready, out_valid, aout0, aout1, aout2, aout3, mask_out
    );

    modport slave (
        input  in_valid, val_0, val_1, mask_in, out_ready,
        output in_ready, out_valid, aout0, aout1, aout2, aout3, mask_out
    );
endinterface

// File: rtl/nzet_scatter.sv
// Scatters up to two nonzero values onto four dense lanes selected by a mask.
// Output register plus skid register; in_ready is registered off the skid state.
module nzet_scatter #(
    parameter int DW = 8
) (
    input  logic        clk,
    input  logic        rst,
    nzet_scatter_if.slave bus,
    input  logic        clr,
    output logic        err_pop,
    output logic [15:0] beat_cnt
);

    logic [3:0]            sel0;
    logic [3:0]            rest;
    logic [3:0]            sel1;
    logic [3:0]            extra;
    logic                  over_pop;
    logic [3:0][DW-1:0]    dec_lane;
    logic [3:0]            dec_mask;

    logic                  in_hs;
    logic                  out_hs;

    logic                  or_valid_q, or_valid_d;
    logic [3:0][DW-1:0]    or_lane_q,  or_lane_d;
    logic [3:0]            or_mask_q,  or_mask_d;
    logic                  sk_valid_q, sk_valid_d;
    logic [3:0][DW-1:0]    sk_lane_q,  sk_lane_d;
    logic [3:0]            sk_mask_q,  sk_mask_d;
    logic                  in_ready_q, in_ready_d;
    logic                  err_pop_q,  err_pop_d;
    logic [15:0]           beat_cnt_q, beat_cnt_d;

    // x & -x isolates the lowest set bit
    assign sel0     = bus.mask_in & (~bus.mask_in + 4'd1);
    assign rest     = bus.mask_in ^ sel0;
    assign sel1     = rest & (~rest + 4'd1);
    assign extra    = rest ^ sel1;
    assign over_pop = |extra;
    assign dec_mask = sel0 | sel1;

    always_comb begin
        dec_lane = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel0[i]) begin
                dec_lane[i] = bus.val_0;
            end else if (sel1[i]) begin
                dec_lane[i] = bus.val_1;
            end
        end
    end

    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = or_valid_q & bus.out_ready;

    always_comb begin
        or_valid_d = or_valid_q;
        or_lane_d  = or_lane_q;
        or_mask_d  = or_mask_q;
        sk_valid_d = sk_valid_q;
        sk_lane_d  = sk_lane_q;
        sk_mask_d  = sk_mask_q;

        if (out_hs || !or_valid_q) begin
            // OR is free this edge; the skid beat is older than any new input
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_lane_d  = sk_lane_q;
                or_mask_d  = sk_mask_q;
                sk_valid_d = 1'b0;
            end else if (in_hs) begin
                or_valid_d = 1'b1;
                or_lane_d  = dec_lane;
                or_mask_d  = dec_mask;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            sk_valid_d = 1'b1;
            sk_lane_d  = dec_lane;
            sk_mask_d  = dec_mask;
        end

        in_ready_d = ~sk_valid_d;

        if (in_hs && over_pop) begin
            err_pop_d = 1'b1;
        end else if (clr) begin
            err_pop_d = 1'b0;
        end else begin
            err_pop_d = err_pop_q;
        end

        if (clr) begin
            beat_cnt_d = 16'd0;
        end else if (out_hs) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_lane_q  <= '0;
            or_mask_q  <= '0;
            sk_valid_q <= 1'b0;
            sk_lane_q  <= '0;
            sk_mask_q  <= '0;
            in_ready_q <= 1'b0;
            err_pop_q  <= 1'b0;
            beat_cnt_q <= 16'd0;
        end else begin
            or_valid_q <= or_valid_d;
            or_lane_q  <= or_lane_d;
            or_mask_q  <= or_mask_d;
            sk_valid_q <= sk_valid_d;
            sk_lane_q  <= sk_lane_d;
            sk_mask_q  <= sk_mask_d;
            in_ready_q <= in_ready_d;
            err_pop_q  <= err_pop_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = or_valid_q;
    assign bus.aout0     = or_lane_q[0];
    assign bus.aout1     = or_lane_q[1];
    assign bus.aout2     = or_lane_q[2];
    assign bus.aout3     = or_lane_q[3];
    assign bus.mask_out  = or_mask_q;
    assign err_pop       = err_pop_q;
    assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_nzet_scatter.sv
// Scoreboard bench for nzet_scatter: directed cases, back-pressure, random traffic, reset and counter clear.
module tb_nzet_scatter;
    localparam int DW = 8;

    typedef struct packed {
        logic [3:0][DW-1:0] lanes;
        logic [3:0]         mask;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        err_pop;
    logic [15:0] beat_cnt;

    nzet_scatter_if #(.DW(DW)) bus ();

    nzet_scatter #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr      (clr),
        .err_pop  (err_pop),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    beat_t       q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode: walk the mask upward, first set bit gets val_0, second val_1
    function automatic beat_t model(input logic [3:0] m, input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        beat_t b;
        int    k;
        b = '0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (k == 0) begin
                    b.lanes[i] = v0;
                    b.mask[i]  = 1'b1;
                end else if (k == 1) begin
                    b.lanes[i] = v1;
                    b.mask[i]  = 1'b1;
                end
                k++;
            end
        end
        return b;
    endfunction

    // Negedge monitor: the values seen here are what the next rising edge acts on
    always @(negedge clk) begin : mon
        beat_t got;
        logic  ihs;
        if (rst) begin
            q.delete();
            exp_cnt = 16'd0;
            exp_err = 1'b0;
        end else begin
            chk("beat_cnt", 64'(beat_cnt), 64'(exp_cnt));
            chk("err_pop", 64'(err_pop), 64'(exp_err));
            if (bus.out_valid) begin
                got = {bus.aout3, bus.aout2, bus.aout1, bus.aout0, bus.mask_out};
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(1), 64'(0));
                end else begin
                    chk("beat", 64'(got), 64'(q[0]));
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            ihs = bus.in_valid & bus.in_ready;
            if (ihs) begin
                q.push_back(model(bus.mask_in, bus.val_0, bus.val_1));
                n_acc++;
            end
            if (ihs && ($countones(bus.mask_in) > 2)) exp_err = 1'b1;
            else if (clr) exp_err = 1'b0;
            if (clr) exp_cnt = 16'd0;
            else if (bus.out_valid && bus.out_ready) exp_cnt = exp_cnt + 16'd1;
        end
    end

    task automatic drive(input logic [3:0] m, input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        bus.mask_in = m;
        bus.val_0   = v0;
        bus.val_1   = v1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
        chk({tag, "_lanes"}, 64'({bus.aout3, bus.aout2, bus.aout1, bus.aout0}), 64'(0));
        chk({tag, "_mask_out"}, 64'(bus.mask_out), 64'(0));
        chk({tag, "_err_pop"}, 64'(err_pop), 64'(0));
        chk({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(0));
    endtask

    initial begin
        int base;
        rst = 1'b0;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(4'd0, '0, '0);

        // Reset acts before any clock edge
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rel_in_ready_low", 64'(bus.in_ready), 64'(0));
        tick();
        chk("rel_in_ready_high", 64'(bus.in_ready), 64'(1));

        // Two-lane scatter with gap
        bus.out_ready = 1'b1;
        drive(4'b1010, 8'h11, 8'h22);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("d1_out_valid", 64'(bus.out_valid), 64'(1));
        chk("d1_lanes", 64'({bus.aout3, bus.aout2, bus.aout1, bus.aout0}), 64'(32'h2200_1100));
        chk("d1_mask", 64'(bus.mask_out), 64'(4'b1010));

        // Over-populated mask: third bit dropped, sticky error
        drive(4'b0111, 8'hA5, 8'h5A);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("d2_lanes", 64'({bus.aout3, bus.aout2, bus.aout1, bus.aout0}), 64'(32'h0000_5AA5));
        chk("d2_mask", 64'(bus.mask_out), 64'(4'b0011));
        chk("d2_err_set", 64'(err_pop), 64'(1));
        repeat (3) tick();
        chk("d2_err_sticky", 64'(err_pop), 64'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("d2_err_clr", 64'(err_pop), 64'(0));
        chk("d2_cnt_clr", 64'(beat_cnt), 64'(0));

        // Clear and over-populated accept on the same edge: set wins
        drive(4'b1111, 8'h01, 8'h02);
        bus.in_valid = 1'b1;
        clr = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        clr = 1'b0;
        chk("d3_err_set_wins", 64'(err_pop), 64'(1));
        chk("d3_mask", 64'(bus.mask_out), 64'(4'b0011));
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Empty mask and single-bit mask
        drive(4'b0000, 8'h77, 8'h88);
        bus.in_valid = 1'b1;
        tick();
        chk("d4_zero_valid", 64'(bus.out_valid), 64'(1));
        chk("d4_zero_lanes", 64'({bus.aout3, bus.aout2, bus.aout1, bus.aout0, bus.mask_out}), 64'(0));
        drive(4'b0100, 8'h33, 8'h44);
        tick();
        bus.in_valid = 1'b0;
        chk("d5_single", 64'({bus.aout3, bus.aout2, bus.aout1, bus.aout0, bus.mask_out}), 64'({32'h0033_0000, 4'b0100}));
        repeat (3) tick();

        // Back-pressure: three offered, two held in OR and SK
        bus.out_ready = 1'b0;
        base = n_acc;
        bus.in_valid = 1'b1;
        drive(4'b0001, 8'h01, 8'h00);
        tick();
        drive(4'b1100, 8'h02, 8'h03);
        tick();
        drive(4'b0110, 8'h04, 8'h05);
        tick();
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        chk("bp_accepted", 64'(n_acc - base), 64'(2));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        repeat (2) tick();
        chk("bp_hold", 64'({bus.aout0, bus.mask_out}), 64'({8'h01, 4'b0001}));
        chk("bp_in_ready_hold", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second", 64'({bus.aout3, bus.aout2, bus.mask_out}), 64'({8'h03, 8'h02, 4'b1100}));
        tick();
        chk("bp_third_acc", 64'(n_acc - base), 64'(3));
        bus.in_valid = 1'b0;
        chk("bp_third", 64'({bus.aout2, bus.aout1, bus.mask_out}), 64'({8'h05, 8'h04, 4'b0110}));
        tick();
        chk("bp_drained", 64'(bus.out_valid), 64'(0));

        // Random traffic on both sides
        clr = 1'b1;
        tick();
        clr = 1'b0;
        base = n_acc;
        for (int i = 0; i < 40000 && (n_acc - base) < 10000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(4'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("rnd_accepted", 64'(n_acc - base), 64'(10000));
        chk("rnd_drained", 64'(q.size()), 64'(0));
        chk("rnd_beat_cnt", 64'(beat_cnt), 64'(10000));

        // Full-rate stream up to 16'hFFFF, then clear on a handshake edge
        for (int i = 0; i < 60000 && exp_cnt != 16'hFFFF; i++) begin
            bus.in_valid = 1'b1;
            drive(4'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        bus.in_valid = 1'b0;
        chk("wrap_at_max", 64'(beat_cnt), 64'(16'hFFFF));
        chk("wrap_out_valid", 64'(bus.out_valid), 64'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("wrap_clr_hs", 64'(beat_cnt), 64'(0));
        repeat (3) tick();

        // Reset with OR and SK full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(4'b1001, 8'hC1, 8'hC2);
        tick();
        drive(4'b0011, 8'hD1, 8'hD2);
        tick();
        bus.in_valid = 1'b0;
        chk("full_in_ready", 64'(bus.in_ready), 64'(0));
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst1");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale", 64'(bus.out_valid), 64'(0));
        end
        chk("post_rst_ready", 64'(bus.in_ready), 64'(1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
